// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Module  : snake_pkg
// Brief   : Shared constants, game-state enum and 7-segment lookup for Snake.
// Revision: 1.0 - initial release
// ============================================================================
package snake_pkg;

    localparam logic [1:0] MSM_IDLE = 2'd0;
    localparam logic [1:0] MSM_PLAY = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WON  = 2'd2,
        ST_LOST = 2'd3
    } game_state_e;

    // Active-low {g..a}; unused codes blank the digit.
    function automatic logic [6:0] seg7(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // Elaboration-time binary to 8-digit BCD, used for parameter constants.
    function automatic logic [31:0] to_bcd(input int unsigned value);
        int unsigned v;
        logic [31:0] r;
        v = value;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_counter.sv
`default_nettype none
// ============================================================================
// Module  : bcd_digit_counter
// Brief   : One BCD digit (0..9) with clear, enable and ripple carry-out.
// Revision: 1.0 - initial release
// ============================================================================
module bcd_digit_counter (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       CLR,
    input  logic       EN,
    output logic [3:0] COUNT,
    output logic       CARRY
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    always_comb begin
        count_d = count_q;
        if (CLR) begin
            count_d = 4'd0;
        end else if (EN) begin
            count_d = (count_q == 4'd9) ? 4'd0 : count_q + 4'd1;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign COUNT = count_q;
    assign CARRY = EN && !CLR && (count_q == 4'd9);

endmodule
`default_nettype wire

// File: rtl/score_timer_display.sv
`default_nettype none
// ============================================================================
// Module  : score_timer_display
// Brief   : Snake score/timer counters, WIN/LOST decision FSM and 7-seg scan.
// Revision: 1.0 - initial release
// ============================================================================
module score_timer_display
    import snake_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int REFRESH_DIV  = 100_000,
    parameter int NUM_DIGITS   = 4,
    parameter int SCORE_DIGITS = 2,
    parameter int TARGET_SCORE = 10,
    parameter int TIME_LIMIT_S = 60,
    parameter int COUNT_DOWN   = 0
) (
    input  logic                      CLK,
    input  logic                      RESETN,
    input  logic                      TARGET_REACHED,
    input  logic                      HIT_WALL,
    input  logic                      TIMED_MODE,
    input  logic [1:0]                MSM_STATE,
    output logic [NUM_DIGITS-1:0]     SEG_SELECT_OUT,
    output logic [7:0]                DEC_OUT,
    output logic [4*SCORE_DIGITS-1:0] SCORE_BCD,
    output logic                      WIN,
    output logic                      LOST
);

    localparam int TIMER_DIGITS = NUM_DIGITS - SCORE_DIGITS;
    localparam int SW           = 4 * SCORE_DIGITS;
    localparam int TW           = 4 * TIMER_DIGITS;
    localparam int PRE_W        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int REF_W        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W        = $clog2(NUM_DIGITS);

    localparam logic [31:0]   TARGET_FULL = to_bcd(TARGET_SCORE);
    localparam logic [31:0]   LIMIT_FULL  = to_bcd(TIME_LIMIT_S);
    localparam logic [SW-1:0] TARGET_BCD  = TARGET_FULL[SW-1:0];
    localparam logic [TW-1:0] LIMIT_BCD   = LIMIT_FULL[TW-1:0];

    game_state_e state_q, state_d;
    logic                  tgt_q, tgt_d;
    logic [PRE_W-1:0]      pre_q, pre_d;
    logic [REF_W-1:0]      ref_q, ref_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic [7:0]            dec_q, dec_d;

    logic [SW-1:0]         score_bcd;
    logic [TW-1:0]         elapsed_bcd, remain_bcd, timer_disp;
    logic [SCORE_DIGITS:0] score_chain;
    logic [TIMER_DIGITS:0] time_chain;
    logic                  playing, clr, sec_tick, unused_carries;
    logic [4:0]            diff;
    logic                  borrow;
    logic [4*NUM_DIGITS-1:0] disp_bcd;
    logic [3:0]            digit;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (MSM_STATE == MSM_PLAY) state_d = ST_RUN;
            ST_RUN: begin
                // Wall beats target, target beats timeout.
                if (MSM_STATE == MSM_IDLE)                           state_d = ST_IDLE;
                else if (HIT_WALL)                                   state_d = ST_LOST;
                else if (score_bcd == TARGET_BCD)                    state_d = ST_WON;
                else if (TIMED_MODE && (elapsed_bcd == LIMIT_BCD))   state_d = ST_LOST;
            end
            ST_WON, ST_LOST: if (MSM_STATE == MSM_IDLE) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        playing  = (state_q == ST_RUN) && (MSM_STATE == MSM_PLAY);
        clr      = (state_d == ST_IDLE);
        tgt_d    = TARGET_REACHED;
        sec_tick = 1'b0;
        pre_d    = pre_q;
        if (clr) begin
            pre_d = '0;
        end else if (playing && TIMED_MODE) begin
            if (pre_q == PRE_W'(CLK_HZ - 1)) begin
                pre_d    = '0;
                sec_tick = 1'b1;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
        score_chain[0] = playing && TARGET_REACHED && !tgt_q && (score_bcd != TARGET_BCD);
        time_chain[0]  = sec_tick && (elapsed_bcd != LIMIT_BCD);
    end

    for (genvar gi = 0; gi < SCORE_DIGITS; gi++) begin : g_score
        bcd_digit_counter u_digit (
            .CLK    (CLK),
            .RESETN (RESETN),
            .CLR    (clr),
            .EN     (score_chain[gi]),
            .COUNT  (score_bcd[4*gi +: 4]),
            .CARRY  (score_chain[gi+1])
        );
    end

    for (genvar gi = 0; gi < TIMER_DIGITS; gi++) begin : g_timer
        bcd_digit_counter u_digit (
            .CLK    (CLK),
            .RESETN (RESETN),
            .CLR    (clr),
            .EN     (time_chain[gi]),
            .COUNT  (elapsed_bcd[4*gi +: 4]),
            .CARRY  (time_chain[gi+1])
        );
    end

    // Top carries cannot fire: both chains saturate below their capacity.
    assign unused_carries = score_chain[SCORE_DIGITS] | time_chain[TIMER_DIGITS];

    always_comb begin
        borrow     = 1'b0;
        diff       = '0;
        remain_bcd = '0;
        for (int i = 0; i < TIMER_DIGITS; i++) begin
            diff = {1'b0, LIMIT_BCD[4*i +: 4]} - {1'b0, elapsed_bcd[4*i +: 4]} - {4'd0, borrow};
            if (diff[4]) begin
                remain_bcd[4*i +: 4] = diff[3:0] + 4'd10;
                borrow               = 1'b1;
            end else begin
                remain_bcd[4*i +: 4] = diff[3:0];
                borrow               = 1'b0;
            end
        end
        if (!TIMED_MODE)          timer_disp = '0;
        else if (COUNT_DOWN != 0) timer_disp = remain_bcd;
        else                      timer_disp = elapsed_bcd;
    end

    always_comb begin
        ref_d = ref_q;
        idx_d = idx_q;
        if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
            ref_d = '0;
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end else begin
            ref_d = ref_q + 1'b1;
        end
        disp_bcd = {timer_disp, score_bcd};
        digit    = disp_bcd[4*idx_q +: 4];
        sel_d    = ~(NUM_DIGITS'(1) << idx_q);
        // Only the timer LSD lights its dot, separating timer from score.
        dec_d    = {(idx_q != IDX_W'(SCORE_DIGITS)), seg7(digit)};
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= ST_IDLE;
            tgt_q   <= 1'b0;
            pre_q   <= '0;
            ref_q   <= '0;
            idx_q   <= '0;
            sel_q   <= '1;
            dec_q   <= 8'hFF;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            pre_q   <= pre_d;
            ref_q   <= ref_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            dec_q   <= dec_d;
        end
    end

    assign SEG_SELECT_OUT = sel_q;
    assign DEC_OUT        = dec_q;
    assign SCORE_BCD      = score_bcd;
    assign WIN            = (state_q == ST_WON);
    assign LOST           = (state_q == ST_LOST);

endmodule
`default_nettype wire
